// File: rtl/apb_uart_tx.sv
// APB-attached UART transmitter: TX FIFO, programmable baud divisor, status register,
// and an 8N1 serializer that sends FIFO bytes LSB first with back-to-back frames.
module apb_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic [1:0]  PSLVERR,
  output logic        UART_TXD,
  output logic        TX_IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // A divisor of zero would stall the bit timer, so it is clamped to one.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    clamp_div = (d == 16'd0) ? 16'd1 : d;
  endfunction

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      bauddiv;
  logic [15:0]      div_q;
  logic [15:0]      timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic       access;
  logic [1:0] reg_sel;
  logic       empty;
  logic       full;
  logic       busy;
  logic       push;
  logic       pop;
  logic       bit_end;
  logic       unused;

  assign access  = PSEL & PENABLE;
  assign reg_sel = PADDR[3:2];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign busy    = (state != IDLE);
  assign bit_end = (timer == div_q - 16'd1);
  assign push    = access & PWRITE & (reg_sel == 2'd0) & ~full;
  assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign unused  = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  assign PREADY = access;

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 2'b00;
    if (access) begin
      case (reg_sel)
        2'd0: if (PWRITE && full) PSLVERR = 2'b10;
        2'd1: if (!PWRITE) PRDATA = {23'b0, busy, full, empty, 6'(count)};
        2'd2: if (!PWRITE) PRDATA = {16'b0, bauddiv};
        default: PSLVERR = 2'b10;
      endcase
    end
  end

  // Data path: FIFO storage, frame shift register and per-frame divisor snapshot.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= PWDATA[7:0];
    if (pop) begin
      shift <= mem[rd_ptr];
      div_q <= bauddiv;
    end else if (bit_end && (state == START || state == DATA)) begin
      shift <= shift >> 1;
    end
  end

  // Control: FIFO pointers, divisor register, serializer FSM and interrupt.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      UART_TXD <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bauddiv  <= DEFAULT_DIV;
      timer    <= '0;
      bit_idx  <= '0;
      TX_IRQ   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      TX_IRQ <= empty & ~busy;
      if (access && PWRITE && reg_sel == 2'd2) bauddiv <= clamp_div(PWDATA[15:0]);

      if (state == IDLE) timer <= '0;
      else               timer <= bit_end ? 16'd0 : timer + 16'd1;

      case (state)
        IDLE: begin
          if (!empty) begin
            state    <= START;
            UART_TXD <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            bit_idx  <= '0;
            UART_TXD <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              UART_TXD <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              UART_TXD <= shift[0];
            end
          end
        end
        default: begin
          if (bit_end) begin
            if (!empty) begin
              state    <= START;
              UART_TXD <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
